// File: rtl/dual_seq_pkg.sv
// Shared definitions for the 101 / 0110 pattern generator: FSM states, patterns, select codes.
// Pure declarations, no timing or flow control of its own.
package dual_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic       SEL_101      = 1'b0;
    localparam logic       SEL_0110     = 1'b1;

    localparam logic [2:0] PAT_101      = 3'b101;
    localparam int         PAT_101_LEN  = 3;
    localparam logic [3:0] PAT_0110     = 4'b0110;
    localparam int         PAT_0110_LEN = 4;

    // Patterns are left-justified so the shifter always starts from bit 3.
    function automatic logic [3:0] pat_word(input logic s);
        return (s == SEL_0110) ? PAT_0110 : {PAT_101, 1'b0};
    endfunction

    function automatic logic [1:0] pat_last(input logic s);
        return (s == SEL_0110) ? 2'(PAT_0110_LEN - 1) : 2'(PAT_101_LEN - 1);
    endfunction

endpackage

// File: rtl/dual_seq_generator_shift.sv
// Load/shift register emitting a left-justified pattern MSB-first; bit_out is a flop.
// Bit appears the cycle after load/shift; drives idle level whenever neither is strobed.
module seq_shift_out #(
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic [3:0] pat,
    input  logic [1:0] last_idx,
    output logic       bit_out,
    output logic       last_bit
);

    logic [3:0] sr;
    logic [1:0] cnt;
    logic [1:0] last_q;
    logic       bit_q;

    // sr holds the bits still to come; bit_q is the bit on the wire now.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr     <= 4'b0000;
            cnt    <= 2'd0;
            last_q <= 2'd0;
            bit_q  <= IDLE_BIT;
        end else if (load) begin
            bit_q  <= pat[3];
            sr     <= {pat[2:0], 1'b0};
            cnt    <= 2'd0;
            last_q <= last_idx;
        end else if (shift) begin
            bit_q  <= sr[3];
            sr     <= {sr[2:0], 1'b0};
            cnt    <= cnt + 2'd1;
        end else begin
            bit_q  <= IDLE_BIT;
        end
    end

    assign bit_out  = bit_q;
    assign last_bit = (cnt == last_q);

endmodule

// File: rtl/dual_seq_generator.sv
// Serial 101 / 0110 pattern source with repeat count and filler gap; all outputs registered.
// First bit one cycle after accepted start; start is ignored (not queued) unless idle.
module dual_seq_generator
    import dual_seq_pkg::*;
#(
    parameter int   REP_W    = 4,
    parameter int   GAP_W    = 3,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sel,
    input  logic [REP_W-1:0] rep,
    input  logic [GAP_W-1:0] gap,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    state_t             state, state_n;
    logic               sel_q;
    logic [REP_W-1:0]   rep_left;
    logic [GAP_W-1:0]   gap_q, gap_cnt;
    logic               valid_q, busy_q, done_q;

    logic               load, shift, latch, rep_dec, gap_ld, gap_dec;
    logic               valid_n, busy_n, done_n;
    logic               load_sel, last_bit;
    logic [3:0]         load_pat;
    logic [1:0]         load_last;

    assign load_sel  = (state == IDLE) ? sel : sel_q;
    assign load_pat  = pat_word(load_sel);
    assign load_last = pat_last(load_sel);

    // Decisions are made one cycle ahead so every output leaves a flop.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        shift   = 1'b0;
        latch   = 1'b0;
        rep_dec = 1'b0;
        gap_ld  = 1'b0;
        gap_dec = 1'b0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (rep != '0) begin
                        latch   = 1'b1;
                        load    = 1'b1;
                        valid_n = 1'b1;
                        busy_n  = 1'b1;
                        state_n = SEND;
                    end else begin
                        done_n  = 1'b1;
                        state_n = FIN;
                    end
                end
            end
            SEND: begin
                if (!last_bit) begin
                    shift   = 1'b1;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end else if (rep_left != '0) begin
                    rep_dec = 1'b1;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    if (gap_q != '0) begin
                        gap_ld  = 1'b1;
                        state_n = GAP;
                    end else begin
                        load    = 1'b1;
                    end
                end else begin
                    done_n  = 1'b1;
                    state_n = FIN;
                end
            end
            GAP: begin
                valid_n = 1'b1;
                busy_n  = 1'b1;
                if (gap_cnt != '0) begin
                    gap_dec = 1'b1;
                end else begin
                    load    = 1'b1;
                    state_n = SEND;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // rep_left counts repetitions still owed after the current one, so rep max never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel_q    <= SEL_101;
            rep_left <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state   <= state_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            if (latch) begin
                sel_q    <= sel;
                rep_left <= rep - REP_W'(1);
                gap_q    <= gap;
            end else if (rep_dec) begin
                rep_left <= rep_left - REP_W'(1);
            end
            if (gap_ld) begin
                gap_cnt <= gap_q - GAP_W'(1);
            end else if (gap_dec) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    seq_shift_out #(
        .IDLE_BIT (IDLE_BIT)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .pat      (load_pat),
        .last_idx (load_last),
        .bit_out  (dout),
        .last_bit (last_bit)
    );

    assign dout_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
